// File: rtl/mem_stage_bridge_if.sv
// mem_stage_bridge_if: handshaked variable-latency data bus between the MEM-stage bridge and memory
interface mem_stage_bridge_if #(parameter int NBITS = 64);
    logic             bus_req;
    logic             bus_we;
    logic [NBITS-1:0] bus_addr;
    logic [NBITS-1:0] bus_wdata;
    logic [7:0]       bus_wstrb;
    logic             bus_ready;
    logic [NBITS-1:0] bus_rdata;
    modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, input bus_ready, bus_rdata);
    modport slave (input bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, output bus_ready, bus_rdata);
endinterface

// File: rtl/mem_stage_bridge.sv
// mem_stage_bridge: turns MEM-stage loads/stores into aligned bus requests, stalling until the bus answers
module mem_stage_bridge #(
    parameter int NBITS   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] wdata,
    input  logic [2:0]       funct3,
    output logic             stall,
    output logic [NBITS-1:0] rdata,
    output logic             misalign,
    output logic             timeout_err,
    mem_stage_bridge_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t           state_q, state_d;
    logic             we_q, we_d, terr_q, terr_d;
    logic [NBITS-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]       wstrb_q, wstrb_d;
    logic [2:0]       off_q, off_d, f3_q, f3_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       off;
    logic             access, illegal, aligned, launch;
    logic [7:0]       strb;
    logic [NBITS-1:0] sh, ext;
    assign off = addr[2:0];
    always_comb begin
        access  = mem_read | mem_write;
        illegal = (funct3 == 3'b111) | (mem_write & funct3[2]);
        aligned = funct3[1:0] == 2'd0 ? 1'b1 :
                  funct3[1:0] == 2'd1 ? ~off[0] :
                  funct3[1:0] == 2'd2 ? off[1:0] == 2'd0 : off == 3'd0;
        strb    = funct3[1:0] == 2'd0 ? 8'h01 << off :
                  funct3[1:0] == 2'd1 ? 8'h03 << off :
                  funct3[1:0] == 2'd2 ? 8'h0F << off : 8'hFF;
        launch  = (state_q == IDLE) & access & ~illegal & aligned;
        sh      = bus.bus_rdata >> {off_q, 3'b000};
        ext     = f3_q == 3'b000 ? {{(NBITS-8){sh[7]}}, sh[7:0]} :
                  f3_q == 3'b001 ? {{(NBITS-16){sh[15]}}, sh[15:0]} :
                  f3_q == 3'b010 ? {{(NBITS-32){sh[31]}}, sh[31:0]} :
                  f3_q == 3'b100 ? {{(NBITS-8){1'b0}}, sh[7:0]} :
                  f3_q == 3'b101 ? {{(NBITS-16){1'b0}}, sh[15:0]} :
                  f3_q == 3'b110 ? {{(NBITS-32){1'b0}}, sh[31:0]} : sh;
    end
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        f3_d    = f3_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: if (launch) begin
                we_d    = mem_write;
                addr_d  = {addr[NBITS-1:3], 3'b000};
                wdata_d = wdata << {off, 3'b000};
                wstrb_d = mem_write ? strb : 8'h00;
                off_d   = off;
                f3_d    = funct3;
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: if (bus.bus_ready) begin
                rdata_d = we_q ? '0 : ext;
                state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                terr_d  = 1'b1;
                rdata_d = '0;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE: begin
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
        end
    end
    // stall and misalign depend on live pipeline inputs, so gate them with reset
    assign stall         = rst & ((state_q == REQ) | launch);
    assign misalign      = rst & (state_q == IDLE) & access & (illegal | ~aligned);
    assign rdata         = rdata_q;
    assign timeout_err   = terr_q;
    assign bus.bus_req   = state_q == REQ;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_stage_bridge.sv
// tb_mem_stage_bridge: directed tests of the MEM-stage bus bridge with a TIMEOUT of 4
module tb_mem_stage_bridge;
    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write;
    logic [63:0] addr, wdata;
    logic [2:0]  funct3;
    logic        stall, misalign, timeout_err;
    logic [63:0] rdata;
    int          checks = 0, errors = 0;
    int          stalls;
    logic        mis, te, stable, bwe;
    logic [63:0] rd, baddr, bwdata;
    logic [7:0]  bstrb;

    mem_stage_bridge_if #(.NBITS(64)) bus ();

    mem_stage_bridge #(.NBITS(64), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .funct3(funct3), .stall(stall), .rdata(rdata),
        .misalign(misalign), .timeout_err(timeout_err), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic retire;
        step;
        mem_read = 1'b0;
        mem_write = 1'b0;
        bus.bus_ready = 1'b0;
        #1;
    endtask

    task automatic access(input logic r, w, input logic [2:0] f3, input logic [63:0] a, wd, rb,
                          input int waits, output int st, output logic ms, output logic [63:0] rdo,
                          output logic teo, output logic stb, output logic [63:0] ba, bw,
                          output logic [7:0] bs, output logic bwo);
        int n;
        logic first;
        mem_read = r; mem_write = w; funct3 = f3; addr = a; wdata = wd;
        bus.bus_rdata = rb; bus.bus_ready = 1'b0;
        #1;
        ms = misalign; st = 0; n = 0; first = 1'b1; stb = 1'b1;
        ba = '0; bw = '0; bs = '0; bwo = 1'b0;
        for (int c = 0; c < 40 && stall; c++) begin
            st++;
            if (bus.bus_req) begin
                n++;
                if (first) begin
                    ba = bus.bus_addr; bw = bus.bus_wdata; bs = bus.bus_wstrb; bwo = bus.bus_we;
                    first = 1'b0;
                end else if (bus.bus_addr !== ba || bus.bus_wdata !== bw || bus.bus_wstrb !== bs || bus.bus_we !== bwo) begin
                    stb = 1'b0;
                end
                bus.bus_ready = (waits >= 0) && (n > waits);
            end
            step;
        end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL access_bound: stall=%b after 40 cycles, expected 0", stall); end
        rdo = rdata; teo = timeout_err;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = '0; wdata = '0; funct3 = 3'b011;
        bus.bus_ready = 1'b0; bus.bus_rdata = '0;
        #1 rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, expected 0", stall); end
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", bus.bus_req); end
        checks++; if ({misalign, timeout_err, bus.bus_we} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, expected 000", {misalign, timeout_err, bus.bus_we}); end
        checks++; if ({rdata, bus.bus_addr, bus.bus_wdata, bus.bus_wstrb} !== '0) begin errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wstrb=%h, expected all 0", rdata, bus.bus_addr, bus.bus_wdata, bus.bus_wstrb); end
        mem_read = 1'b0;
        @(negedge clk) rst = 1'b1;
        step;
    endtask

    task automatic test_load_double;
        access(1, 0, 3'b011, 64'h100, 0, 64'h1122334455667788, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (stalls !== 2) begin errors++; $display("FAIL ld_stalls: got %0d, expected 2", stalls); end
        checks++; if (baddr !== 64'h100) begin errors++; $display("FAIL ld_addr: got %h, expected 100", baddr); end
        checks++; if ({bwe, bstrb} !== 9'h000) begin errors++; $display("FAIL ld_we_strb: got %b/%h, expected 0/00", bwe, bstrb); end
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld_rdata: got %h, expected 1122334455667788", rd); end
        checks++; if ({bus.bus_req, te, mis} !== 3'b000) begin errors++; $display("FAIL ld_done_flags: got %b, expected 000", {bus.bus_req, te, mis}); end
        retire;
        checks++; if ({bus.bus_req, stall, rdata != 64'h0} !== 3'b000) begin errors++; $display("FAIL ld_no_relaunch: req/stall/rdata!=0 got %b, expected 000", {bus.bus_req, stall, rdata != 64'h0}); end
    endtask

    task automatic test_load_extend;
        access(1, 0, 3'b000, 64'h107, 0, 64'h8000000000000000, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h, expected FFFFFFFFFFFFFF80", rd); end
        checks++; if (baddr !== 64'h100) begin errors++; $display("FAIL lb_addr: got %h, expected 100", baddr); end
        retire;
        access(1, 0, 3'b100, 64'h107, 0, 64'h8000000000000000, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (rd !== 64'h80) begin errors++; $display("FAIL lbu_rdata: got %h, expected 80", rd); end
        retire;
        access(1, 0, 3'b001, 64'h106, 0, 64'hABCD000000000000, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (rd !== 64'hFFFFFFFFFFFFABCD) begin errors++; $display("FAIL lh_rdata: got %h, expected FFFFFFFFFFFFABCD", rd); end
        retire;
        access(1, 0, 3'b101, 64'h106, 0, 64'hABCD000000000000, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (rd !== 64'h000000000000ABCD) begin errors++; $display("FAIL lhu_rdata: got %h, expected ABCD", rd); end
        retire;
        access(1, 0, 3'b110, 64'h104, 0, 64'h87654321DEADBEEF, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (rd !== 64'h0000000087654321) begin errors++; $display("FAIL lwu_rdata: got %h, expected 87654321", rd); end
        retire;
    endtask

    task automatic test_store;
        access(0, 1, 3'b001, 64'h22, 64'hBEEF, 64'hFFFFFFFFFFFFFFFF, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (baddr !== 64'h20) begin errors++; $display("FAIL sh_addr: got %h, expected 20", baddr); end
        checks++; if (bstrb !== 8'h0C) begin errors++; $display("FAIL sh_strb: got %h, expected 0C", bstrb); end
        checks++; if (bwdata !== 64'h00000000BEEF0000) begin errors++; $display("FAIL sh_wdata: got %h, expected 00000000BEEF0000", bwdata); end
        checks++; if ({bwe, rd != 64'h0} !== 2'b10) begin errors++; $display("FAIL sh_we_rdata: we/rdata!=0 got %b, expected 10", {bwe, rd != 64'h0}); end
        retire;
        access(1, 1, 3'b000, 64'h5, 64'h5A, 0, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if ({bwe, bstrb} !== 9'h120) begin errors++; $display("FAIL both_set_we_strb: got %b/%h, expected 1/20", bwe, bstrb); end
        checks++; if (bwdata !== 64'h00005A0000000000) begin errors++; $display("FAIL both_set_wdata: got %h, expected 00005A0000000000", bwdata); end
        retire;
    endtask

    task automatic test_misalign;
        access(1, 0, 3'b010, 64'h102, 0, 0, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if ({mis, stalls != 0, rd != 64'h0} !== 3'b100) begin errors++; $display("FAIL lw_misalign: mis/stalled/rdata!=0 got %b, expected 100", {mis, stalls != 0, rd != 64'h0}); end
        retire;
        checks++; if ({misalign, bus.bus_req, stall} !== 3'b000) begin errors++; $display("FAIL lw_misalign_after: got %b, expected 000", {misalign, bus.bus_req, stall}); end
        access(0, 1, 3'b110, 64'h0, 0, 0, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if ({mis, stalls != 0} !== 2'b10) begin errors++; $display("FAIL store_unsigned_illegal: got %b, expected 10", {mis, stalls != 0}); end
        retire;
        access(1, 0, 3'b111, 64'h0, 0, 0, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if ({mis, stalls != 0} !== 2'b10) begin errors++; $display("FAIL funct3_111_illegal: got %b, expected 10", {mis, stalls != 0}); end
        retire;
        access(0, 1, 3'b011, 64'h4, 0, 0, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if ({mis, stalls != 0} !== 2'b10) begin errors++; $display("FAIL sd_misalign: got %b, expected 10", {mis, stalls != 0}); end
        retire;
    endtask

    task automatic test_wait_states;
        access(0, 1, 3'b011, 64'h200, 64'h0123456789ABCDEF, 0, 3, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (stalls !== 5) begin errors++; $display("FAIL sd_wait_stalls: got %0d, expected 5", stalls); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL sd_wait_stable: got %b, expected 1", stable); end
        checks++; if ({bstrb, baddr, bwdata} !== {8'hFF, 64'h200, 64'h0123456789ABCDEF}) begin errors++; $display("FAIL sd_wait_bus: strb=%h addr=%h wdata=%h, expected FF/200/0123456789ABCDEF", bstrb, baddr, bwdata); end
        checks++; if (te !== 1'b0) begin errors++; $display("FAIL sd_wait_terr: got %b, expected 0", te); end
        retire;
    endtask

    task automatic test_timeout;
        access(1, 0, 3'b011, 64'h300, 0, 64'hFFFFFFFFFFFFFFFF, -1, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (stalls !== 5) begin errors++; $display("FAIL timeout_stalls: got %0d, expected 5", stalls); end
        checks++; if ({te, bus.bus_req} !== 2'b10) begin errors++; $display("FAIL timeout_done: terr/req got %b, expected 10", {te, bus.bus_req}); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL timeout_rdata: got %h, expected 0", rd); end
        retire;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b, expected 0", timeout_err); end
        bus.bus_ready = 1'b1;
        step;
        checks++; if ({bus.bus_req, stall, rdata != 64'h0} !== 3'b000) begin errors++; $display("FAIL idle_ready_ignored: got %b, expected 000", {bus.bus_req, stall, rdata != 64'h0}); end
        bus.bus_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 64'h0; bus.bus_ready = 1'b0;
        step;
        step;
        checks++; if (bus.bus_req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b, expected 1", bus.bus_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.bus_req, stall} !== 2'b00) begin errors++; $display("FAIL mid_reset_drop: req/stall got %b, expected 00", {bus.bus_req, stall}); end
        mem_read = 1'b0;
        @(negedge clk) rst = 1'b1;
        step;
        access(1, 0, 3'b010, 64'h0, 0, 64'hDEADBEEF87654321, 0, stalls, mis, rd, te, stable, baddr, bwdata, bstrb, bwe);
        checks++; if (rd !== 64'hFFFFFFFF87654321) begin errors++; $display("FAIL post_reset_lw: got %h, expected FFFFFFFF87654321", rd); end
        checks++; if (stalls !== 2) begin errors++; $display("FAIL post_reset_stalls: got %0d, expected 2", stalls); end
        retire;
    endtask

    initial begin
        test_reset;
        test_load_double;
        test_load_extend;
        test_store;
        test_misalign;
        test_wait_states;
        test_timeout;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
